bcd_counter_2dig: RTL and testbench

BCD_COUNTER_2DIG -- requirements
Module: bcd_counter_2dig

---
 rtl/bcd_counter_2dig_pkg.sv | 57 +++++
 rtl/key_debounce.sv | 53 +++++
 rtl/bcd_counter_2dig.sv | 126 ++++++++++++
 tb/tb_bcd_counter_2dig.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_2dig_pkg.sv
// rtl/bcd_counter_2dig_pkg.sv - shared types and BCD step helper for the two-digit counter
//
// Purpose: run/pause state encoding, the largest BCD digit value, and a pure
//          function that computes the next two-digit BCD value for one count.
// Ports:   none (package).
package bcd_counter_2dig_pkg;

   typedef enum logic {
      ST_PAUSE = 1'b0,
      ST_RUN   = 1'b1
   } run_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       wrap;
   } bcd_step_t;

   // One count step in either direction; wrap flags 99->00 (up) or 00->99 (down).
   function automatic bcd_step_t bcd_step(input logic [3:0] tens,
                                          input logic [3:0] ones,
                                          input logic       up);
      bcd_step_t r;
      r.tens = tens;
      r.ones = ones;
      r.wrap = 1'b0;
      if (up) begin
         if (ones >= BCD_MAX) begin
            r.ones = 4'd0;
            if (tens >= BCD_MAX) begin
               r.tens = 4'd0;
               r.wrap = 1'b1;
            end else begin
               r.tens = tens + 4'd1;
            end
         end else begin
            r.ones = ones + 4'd1;
         end
      end else begin
         if (ones == 4'd0) begin
            r.ones = BCD_MAX;
            if (tens == 4'd0) begin
               r.tens = BCD_MAX;
               r.wrap = 1'b1;
            end else begin
               r.tens = tens - 4'd1;
            end
         end else begin
            r.ones = ones - 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-key synchronizer, debouncer and press-pulse generator
//
// Purpose: brings an asynchronous active-low key into the clk domain, accepts a
//          new level only after DEB_CYCLES consecutive equal samples, and emits
//          a one-cycle pulse when the accepted level falls (key pressed).
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   key_n  in   raw active-low key
//   press  out  one-cycle pulse on an accepted press
module key_debounce #(
   parameter int DEB_CYCLES = 240000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] stable_cnt;

   // stable_cnt counts consecutive samples that differ from the accepted level;
   // the DEB_CYCLES-th such sample flips the accepted level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1     <= 1'b1;
         sync_2     <= 1'b1;
         level      <= 1'b1;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            level      <= sync_2;
            stable_cnt <= '0;
            press      <= ~sync_2;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_counter_2dig.sv
// rtl/bcd_counter_2dig.sv - two-digit BCD up/down counter with run/pause and clear keys
//
// Purpose: counts 00..99 at TICK_HZ while running, in the direction chosen by
//          up_dn, with debounced run/pause toggle and clear keys.
// Ports:
//   clk         in   system clock (CLK_HZ)
//   rst_n       in   asynchronous active-low reset
//   key_run_n   in   active-low key, toggles run/pause
//   key_clr_n   in   active-low key, clears digits and prescaler
//   up_dn       in   level switch, 1 = up, 0 = down
//   seg_data_1  out  tens digit (BCD)
//   seg_data_2  out  ones digit (BCD)
//   wrap        out  one-cycle pulse on 99->00 or 00->99
//   running     out  1 while in RUN
module bcd_counter_2dig
   import bcd_counter_2dig_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int TICK_HZ    = 1,
   parameter int DEB_CYCLES = 240000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_run_n,
   input  logic       key_clr_n,
   input  logic       up_dn,
   output logic [3:0] seg_data_1,
   output logic [3:0] seg_data_2,
   output logic       wrap,
   output logic       running
);

   localparam int            DIV      = CLK_HZ / TICK_HZ;
   localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

   logic          run_press;
   logic          clr_press;
   logic          up_s1;
   logic          up_s2;
   run_state_t    state;
   run_state_t    state_next;
   logic [PW-1:0] psc;
   logic          tick;
   logic [3:0]    tens;
   logic [3:0]    ones;
   bcd_step_t     step;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_run_n),
      .press (run_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_clr_n),
      .press (clr_press)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_s1 <= 1'b1;
         up_s2 <= 1'b1;
      end else begin
         up_s1 <= up_dn;
         up_s2 <= up_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_PAUSE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (run_press) begin
         state_next = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   assign running = (state == ST_RUN);
   assign tick    = running && (psc == PSC_LAST);

   // In PAUSE the prescaler holds so a resume continues the partial period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc <= '0;
      end else if (clr_press) begin
         psc <= '0;
      end else if (running) begin
         psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
      end
   end

   assign step = bcd_step(tens, ones, up_s2);

   // Clear has priority over a coincident tick, suppressing both count and wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens <= 4'd0;
         ones <= 4'd0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr_press) begin
            tens <= 4'd0;
            ones <= 4'd0;
         end else if (tick) begin
            tens <= step.tens;
            ones <= step.ones;
            wrap <= step.wrap;
         end
      end
   end

   assign seg_data_1 = tens;
   assign seg_data_2 = ones;

endmodule

// File: tb/tb_bcd_counter_2dig.sv
// tb/tb_bcd_counter_2dig.sv - directed self-checking bench for bcd_counter_2dig
module tb_bcd_counter_2dig;

   logic       clk;
   logic       rst_n;
   logic       key_run_n;
   logic       key_clr_n;
   logic       up_dn;
   logic [3:0] seg_data_1;
   logic [3:0] seg_data_2;
   logic       wrap;
   logic       running;

   int vectors     = 0;
   int miscompares = 0;
   int n           = 0;
   int toggles     = 0;
   logic run_prev  = 1'b0;

   bcd_counter_2dig #(
      .CLK_HZ     (100),
      .TICK_HZ    (10),
      .DEB_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_run_n  (key_run_n),
      .key_clr_n  (key_clr_n),
      .up_dn      (up_dn),
      .seg_data_1 (seg_data_1),
      .seg_data_2 (seg_data_2),
      .wrap       (wrap),
      .running    (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (running !== run_prev) toggles++;
      run_prev = running;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] digits();
      return {seg_data_1, seg_data_2};
   endfunction

   task automatic wait_to(input int target);
      while (n < target) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Key(s) held low 6 cycles; the effect lands just before the 7th negedge.
   task automatic press(input logic run, input logic clr);
      key_run_n = ~run;
      key_clr_n = ~clr;
      repeat (6) @(negedge clk);
      key_run_n = 1'b1;
      key_clr_n = 1'b1;
      @(negedge clk);
      n += 7;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      key_run_n = 1'b1;
      key_clr_n = 1'b1;
      up_dn     = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic start_run();
      do_reset();
      press(1'b1, 1'b0);
      n = 0;
   endtask

   initial begin
      rst_n     = 1'b0;
      key_run_n = 1'b1;
      key_clr_n = 1'b1;
      up_dn     = 1'b1;
      #3;
      check("rst_digits", digits(), 8'h00);
      check("rst_wrap", {7'd0, wrap}, 8'h00);
      check("rst_running", {7'd0, running}, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Run press latency and first ticks
      key_run_n = 1'b0;
      repeat (6) @(negedge clk);
      check("run_before_toggle", {7'd0, running}, 8'h00);
      key_run_n = 1'b1;
      @(negedge clk);
      check("run_after_toggle", {7'd0, running}, 8'h01);
      n = 0;
      wait_to(9);    check("tick1_pre", digits(), 8'h00);
      wait_to(10);   check("tick1", digits(), 8'h01);
      wait_to(19);   check("tick2_pre", digits(), 8'h01);
      wait_to(20);   check("tick2", digits(), 8'h02);
      wait_to(99);   check("cnt_09", digits(), 8'h09);
      wait_to(100);  check("carry_10", digits(), 8'h10);

      // Up wrap 99->00, then down wrap 00->99
      wait_to(990);  check("cnt_99", digits(), 8'h99);
      wait_to(999);  check("pre_wrap", {7'd0, wrap}, 8'h00);
      wait_to(1000);
      check("up_wrap_digits", digits(), 8'h00);
      check("up_wrap_pulse", {7'd0, wrap}, 8'h01);
      wait_to(1001); check("up_wrap_end", {7'd0, wrap}, 8'h00);
      up_dn = 1'b0;
      wait_to(1004); check("updn_edge_hold", digits(), 8'h00);
      wait_to(1010);
      check("dn_wrap_digits", digits(), 8'h99);
      check("dn_wrap_pulse", {7'd0, wrap}, 8'h01);
      wait_to(1011); check("dn_wrap_end", {7'd0, wrap}, 8'h00);
      wait_to(1020); check("dn_98", digits(), 8'h98);

      // Bouncing run key gives exactly one toggle
      do_reset();
      toggles = 0;
      for (int i = 0; i < 6; i++) begin
         key_run_n = i[0];
         repeat (2) @(negedge clk);
      end
      key_run_n = 1'b0;
      check("bounce_no_toggle", {7'd0, running}, 8'h00);
      repeat (10) @(negedge clk);
      key_run_n = 1'b1;
      repeat (10) @(negedge clk);
      check("bounce_running", {7'd0, running}, 8'h01);
      check("bounce_toggles", 8'(toggles), 8'h01);

      // Clear coincident with the tick at 37, then run+clear together
      start_run();
      wait_to(373);  check("pre_clear_37", digits(), 8'h37);
      press(1'b0, 1'b1);
      check("clr_digits", digits(), 8'h00);
      check("clr_no_wrap", {7'd0, wrap}, 8'h00);
      check("clr_running", {7'd0, running}, 8'h01);
      wait_to(389);  check("post_clr_hold", digits(), 8'h00);
      wait_to(390);  check("post_clr_tick", digits(), 8'h01);
      wait_to(395);
      press(1'b1, 1'b1);
      check("both_digits", digits(), 8'h00);
      check("both_running", {7'd0, running}, 8'h00);
      wait_to(430);  check("both_paused", digits(), 8'h00);

      // Pause at 05 with prescaler at 6, resume continues from 6
      start_run();
      wait_to(49);   check("pre_pause_04", digits(), 8'h04);
      press(1'b1, 1'b0);
      check("pause_state", {7'd0, running}, 8'h00);
      check("pause_05", digits(), 8'h05);
      wait_to(106);  check("pause_held", digits(), 8'h05);
      press(1'b1, 1'b0);
      check("resume_state", {7'd0, running}, 8'h01);
      wait_to(116);  check("resume_pre", digits(), 8'h05);
      wait_to(117);  check("resume_06", digits(), 8'h06);

      // Asynchronous reset mid-count
      start_run();
      wait_to(425);  check("pre_rst_42", digits(), 8'h42);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_digits", digits(), 8'h00);
      check("async_rst_wrap", {7'd0, wrap}, 8'h00);
      check("async_rst_running", {7'd0, running}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("post_rst_digits", digits(), 8'h00);
      check("post_rst_running", {7'd0, running}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
